intc_sched: RTL and testbench
=============================

# intc_sched

Programmable interrupt scheduler between the raw interrupt sources (Timer0 IRQ, Timer1 IRQ, external interrupt, spares) and the CP0 `HWInt` input. Sources are latched, masked and prioritised, and exactly one at a time is delivered to CP0. Each delivery is held until software writes an end-of-interrupt (EOI). The block is memory-mapped behind the Bridge as a third peripheral, word-addressed like the timers.

## Interface
- `NUM_SRC`, default 6: number of interrupt sources; must be ≤ 8. Bit *i* of every vector belongs to source *i*.
- `clk` in 1: single clock for all state.
- `reset` in 1: synchronous, active-high; clears all state on the rising edge of `clk`.
- `irq_in` in NUM_SRC: raw requests, already synchronous to `clk`. Bit 0 is T0IRQ, bit 1 is T1IRQ, bit 2 is the external `interrupt`.
- `Addr` in 30: word address `[31:2]`. Only `Addr[3:2]` is decoded; the Bridge supplies the chip select through `WE` and the read-data mux.
- `WE` in 1: register write strobe from the Bridge.
- `Din` in 32: write data.
- `Dout` out 32: combinational read data for `Addr[3:2]`.
- `hwint_out` out NUM_SRC: one-hot registered delivery to CP0 `HWInt`; all zeros when idle.
- `busy` out 1: high while a delivery is in service.

## Operation
- Register map by `Addr[3:2]`:
  - 0 `MASK` (RW): 1 enables the source.
  - 1 `MODE` (RW): 1 = edge, 0 = level.
  - 2 `PEND` (R; write-1-to-clear, edge sources only).
  - 3 `VECT` (R `{busy, 28'b0, id[2:0]}`; any write = EOI).
- Unused upper bits read 0 and ignore writes.
- Level source: `PEND[i]` = `irq_in[i]` sampled each cycle; not latched.
- Edge source: `PEND[i]` is set on a 0→1 transition of `irq_in[i]` relative to the previous cycle's sample. It stays set until cleared by W1C or by being granted.
- Eligible = `PEND & MASK`. Priority is fixed: lowest index wins.
- FSM states:
  - IDLE: if eligible ≠ 0, go to SERVICE. Latch `id` = lowest eligible index, set `hwint_out` = one-hot(`id`), and clear `PEND[id]` if that source is edge mode.
  - SERVICE: hold `id` and `hwint_out` regardless of later MASK/MODE/PEND changes. An EOI write returns to IDLE, clears `hwint_out` and keeps `id` readable.
- EOI while in IDLE: ignored.
- W1C of a pending bit whose edge arrives in the same cycle: set wins.
- A level source still asserted after EOI is re-delivered.
- Writing MODE changes only future sampling; current PEND is not cleared.

## Timing
- Reset values: MASK=0, MODE=0, PEND=0, edge history=0, state=IDLE, id=0, `hwint_out`=0, `busy`=0. `Dout` follows `Addr` immediately after reset.
- Edge source: edge seen at cycle N → PEND set at N+1 → `hwint_out` at N+2.
- Level source: asserted at N → PEND visible at N+1 → `hwint_out` at N+2.
- EOI write at cycle E → `hwint_out`=0 and `busy`=0 at E+1. The earliest next delivery is at E+2, so there is a minimum 1-cycle gap between deliveries.
- Register writes take effect on the next edge, and a write to MASK at cycle N affects arbitration from cycle N+1.
- Reset asserted mid-SERVICE → IDLE with `hwint_out`=0 on the next edge; pending edges are lost.

## Configuration
- `INTC_EDGE_EN` defined: MODE register, edge-detect history register and PEND W1C logic are present as specified.
- `INTC_EDGE_EN` undefined:
  - All sources are level-sensitive.
  - MODE reads 0 and ignores writes; PEND W1C is ignored.
  - No edge history flops. Latency is otherwise unchanged.

## Structure
- Shared package `intc_pkg`:
  - register offsets (`INTC_MASK`=2'd0, `INTC_MODE`=2'd1, `INTC_PEND`=2'd2, `INTC_VECT`=2'd3);
  - FSM state encoding (`INTC_IDLE`, `INTC_SERVICE`);
  - default `NUM_SRC`.
- Sub-module `intc_prio_enc`: combinational lowest-index-first finder producing `{valid, id, onehot}` from the eligible vector.

## Test plan
- Reset, MASK=6'b000001, level `irq_in[0]` raised at cycle 10 → `hwint_out`=6'b000001 at cycle 12. VECT reads 0x80000000. EOI with irq still high → `hwint_out` low at next cycle, high again one cycle later.
- MASK=6'b000111, `irq_in[2]` and `irq_in[1]` raised in the same cycle → `hwint_out`=6'b000010, id=1. After EOI and both lines dropped, source 2 is not delivered (level).
- MODE=6'b000100, MASK=6'b000100, 1-cycle pulse on `irq_in[2]` → PEND[2] set, delivered with `hwint_out`=6'b000100, PEND reads 0 during SERVICE.
- During SERVICE of id 2, higher-priority source 0 asserts → `hwint_out` stays 6'b000100 until EOI, then id 0 is delivered one cycle later.
- Edge pulse and W1C on PEND[2] in the same cycle → PEND[2] remains 1. EOI written in IDLE → no state change.
- `reset` asserted while `busy`=1 → next cycle `hwint_out`=0, MASK=0, VECT=0. Repeat with `INTC_EDGE_EN` undefined: MODE reads 0 after writing 0x3F.

Source files
------------

// File: rtl/intc_pkg.sv
// intc_pkg: shared definitions for the interrupt scheduler.
// Holds the register offsets (word address bits [3:2]), the FSM state
// encoding, the VECT read-back layout and the default source count.
// The optional edge-detect feature is enabled with the INTC_EDGE_EN macro.
package intc_pkg;

    localparam int unsigned INTC_NUM_SRC = 6;
    localparam int unsigned INTC_MAX_SRC = 8;
    localparam int unsigned INTC_ID_W    = 3;
    localparam int unsigned INTC_DATA_W  = 32;

    localparam logic [1:0] INTC_MASK = 2'd0;
    localparam logic [1:0] INTC_MODE = 2'd1;
    localparam logic [1:0] INTC_PEND = 2'd2;
    localparam logic [1:0] INTC_VECT = 2'd3;

    typedef enum logic {
        INTC_IDLE    = 1'b0,
        INTC_SERVICE = 1'b1
    } intc_state_e;

    // VECT register layout: {busy, 28'b0, id}
    typedef struct packed {
        logic                 busy;
        logic [27:0]          zero;
        logic [INTC_ID_W-1:0] id;
    } intc_vect_t;

endpackage

// File: rtl/intc_prio_enc.sv
// intc_prio_enc: combinational fixed-priority finder, lowest index wins.
// Ports:
//   eligible_i  - masked pending vector
//   valid_o     - any source eligible
//   id_o        - index of the winning source
//   onehot_o    - one-hot of the winning source (zero when none)
module intc_prio_enc
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = INTC_NUM_SRC
) (
    input  logic [NUM_SRC-1:0]   eligible_i,
    output logic                 valid_o,
    output logic [INTC_ID_W-1:0] id_o,
    output logic [NUM_SRC-1:0]   onehot_o
);

    // Scan from the top down so the last hit (lowest index) wins.
    always_comb begin
        valid_o  = |eligible_i;
        id_o     = '0;
        onehot_o = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible_i[i]) begin
                id_o        = INTC_ID_W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intc_sched.sv
// intc_sched: programmable interrupt scheduler feeding CP0 HWInt.
// Latches, masks and prioritises NUM_SRC requests and delivers one at a
// time; each delivery is held until software writes VECT (EOI).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   irq_in      - raw requests (bit0 T0IRQ, bit1 T1IRQ, bit2 external)
//   Addr, WE    - word address [31:2] (only [3:2] decoded), write strobe
//   Din, Dout   - write data, combinational read data
//   hwint_out   - registered one-hot delivery, zero when idle
//   busy        - a delivery is in service
// Macro INTC_EDGE_EN adds the MODE register, edge history and PEND W1C;
// without it every source is level-sensitive.
module intc_sched
    import intc_pkg::*;
#(
    parameter int unsigned NUM_SRC = INTC_NUM_SRC
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     irq_in,
    input  logic [29:0]            Addr,
    input  logic                   WE,
    input  logic [INTC_DATA_W-1:0] Din,
    output logic [INTC_DATA_W-1:0] Dout,
    output logic [NUM_SRC-1:0]     hwint_out,
    output logic                   busy
);

    logic [NUM_SRC-1:0]   mask_q;
    logic [NUM_SRC-1:0]   pend_q;
    logic [NUM_SRC-1:0]   pend_d;
    logic [NUM_SRC-1:0]   mode_v;
    logic [NUM_SRC-1:0]   eligible;
    logic [NUM_SRC-1:0]   pe_onehot;
    logic                 pe_valid;
    logic [INTC_ID_W-1:0] pe_id;
    logic [INTC_ID_W-1:0] id_q;
    logic [NUM_SRC-1:0]   hwint_q;
    logic                 busy_q;
    intc_state_e          state_q;
    logic [1:0]           reg_sel;
    logic                 wr_mask;
    logic                 wr_vect;
    logic                 grant;
    intc_vect_t           vect;
    logic                 unused_bits;

    assign reg_sel  = Addr[1:0];
    assign wr_mask  = WE && (reg_sel == INTC_MASK);
    assign wr_vect  = WE && (reg_sel == INTC_VECT);
    assign eligible = pend_q & mask_q;
    assign grant    = (state_q == INTC_IDLE) && pe_valid;

    assign unused_bits = ^{Addr[29:2], Din[INTC_DATA_W-1:NUM_SRC]};

    intc_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .eligible_i (eligible),
        .valid_o    (pe_valid),
        .id_o       (pe_id),
        .onehot_o   (pe_onehot)
    );

`ifdef INTC_EDGE_EN
    logic [NUM_SRC-1:0] mode_q;
    logic [NUM_SRC-1:0] hist_q;
    logic [NUM_SRC-1:0] edge_set;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] grant_clr;
    logic               wr_mode;
    logic               wr_pend;

    assign wr_mode   = WE && (reg_sel == INTC_MODE);
    assign wr_pend   = WE && (reg_sel == INTC_PEND);
    assign edge_set  = irq_in & ~hist_q;
    assign w1c       = wr_pend ? Din[NUM_SRC-1:0] : '0;
    assign grant_clr = grant ? (pe_onehot & mode_q) : '0;
    assign mode_v    = mode_q;

    // Mode register and previous-cycle sample for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
            hist_q <= '0;
        end else begin
            hist_q <= irq_in;
            if (wr_mode) begin
                mode_q <= Din[NUM_SRC-1:0];
            end
        end
    end

    // Edge bits hold until W1C or grant; a coincident new edge beats both.
    always_comb begin
        pend_d = irq_in;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (mode_q[i]) begin
                pend_d[i] = edge_set[i] | (pend_q[i] & ~w1c[i] & ~grant_clr[i]);
            end
        end
    end
`else
    assign mode_v = '0;
    assign pend_d = irq_in;
`endif

    // Register state and delivery FSM.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= '0;
            pend_q  <= '0;
            state_q <= INTC_IDLE;
            id_q    <= '0;
            hwint_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            if (wr_mask) begin
                mask_q <= Din[NUM_SRC-1:0];
            end
            pend_q <= pend_d;
            case (state_q)
                INTC_IDLE: begin
                    if (pe_valid) begin
                        state_q <= INTC_SERVICE;
                        id_q    <= pe_id;
                        hwint_q <= pe_onehot;
                        busy_q  <= 1'b1;
                    end
                end
                INTC_SERVICE: begin
                    // id stays readable after EOI
                    if (wr_vect) begin
                        state_q <= INTC_IDLE;
                        hwint_q <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= INTC_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        vect      = '0;
        vect.busy = busy_q;
        vect.id   = id_q;
    end

    // Read mux; VECT is the default leg.
    always_comb begin
        Dout = '0;
        case (reg_sel)
            INTC_MASK: Dout[NUM_SRC-1:0] = mask_q;
            INTC_MODE: Dout[NUM_SRC-1:0] = mode_v;
            INTC_PEND: Dout[NUM_SRC-1:0] = pend_q;
            default:   Dout = INTC_DATA_W'(vect);
        endcase
    end

    assign hwint_out = hwint_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_intc_sched.sv
// tb_intc_sched: directed bench for intc_sched with a delivery scoreboard.
// Stimulus pushes each expected delivery (one-hot + cycle); a monitor pops
// and compares on every rising edge of busy. Edge-mode checks are built
// only when INTC_EDGE_EN is defined.
module tb_intc_sched;
    import intc_pkg::*;

    localparam int unsigned NS = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic [NS-1:0] irq_in;
    logic [29:0]   Addr;
    logic          WE;
    logic [31:0]   Din;
    logic [31:0]   Dout;
    logic [NS-1:0] hwint_out;
    logic          busy;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    typedef struct packed {
        logic [NS-1:0] onehot;
        logic [31:0]   cyc;
    } exp_t;

    exp_t sb_q[$];
    logic busy_prev = 1'b0;

    intc_sched #(
        .NUM_SRC (NS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in    (irq_in),
        .Addr      (Addr),
        .WE        (WE),
        .Din       (Din),
        .Dout      (Dout),
        .hwint_out (hwint_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every new delivery must match the head of the scoreboard.
    always @(negedge clk) begin
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            exp_t e;
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL delivery: unexpected hwint_out=%b at cycle %0d", hwint_out, cyc);
            end else begin
                e = sb_q.pop_front();
                if (hwint_out !== e.onehot || 32'(cyc) !== e.cyc) begin
                    errors++;
                    $display("FAIL delivery: got hwint_out=%b at cycle %0d, expected %b at cycle %0d",
                             hwint_out, cyc, e.onehot, e.cyc);
                end
            end
        end
        busy_prev = busy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = 30'(a);
        Din  = d;
        WE   = 1'b1;
        tick(1);
        WE   = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp_v, input string name);
        Addr = 30'(a);
        #1;
        chk(name, Dout, exp_v);
    endtask

    task automatic expect_at(input logic [NS-1:0] oh, input int dly);
        exp_t e;
        e.onehot = oh;
        e.cyc    = 32'(cyc + dly);
        sb_q.push_back(e);
    endtask

    initial begin
        reset  = 1'b1;
        irq_in = '0;
        Addr   = '0;
        WE     = 1'b0;
        Din    = '0;
        tick(3);

        // Reset state
        chk("rst_hwint", 32'(hwint_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        rd(INTC_MASK, 32'h0, "rst_mask");
        rd(INTC_MODE, 32'h0, "rst_mode");
        rd(INTC_PEND, 32'h0, "rst_pend");
        rd(INTC_VECT, 32'h0, "rst_vect");
        reset = 1'b0;
        tick(1);

        // Level source 0: delivery two cycles after assertion, re-delivered after EOI
        wr(INTC_MASK, 32'h01);
        irq_in[0] = 1'b1;
        expect_at(6'b000001, 2);
        tick(2);
        chk("lvl0_hwint", 32'(hwint_out), 32'h01);
        rd(INTC_VECT, 32'h8000_0000, "lvl0_vect");
        expect_at(6'b000001, 2);
        wr(INTC_VECT, 32'h0);
        chk("lvl0_eoi_hwint", 32'(hwint_out), 32'h0);
        chk("lvl0_eoi_busy", 32'(busy), 32'h0);
        tick(1);
        chk("lvl0_redeliver", 32'(hwint_out), 32'h01);
        irq_in[0] = 1'b0;
        tick(2);
        wr(INTC_VECT, 32'h0);
        tick(3);
        chk("lvl0_quiet", 32'(hwint_out), 32'h0);

        // Simultaneous 1 and 2: source 1 wins; level source 2 gone after drop
        wr(INTC_MASK, 32'h07);
        irq_in[2:1] = 2'b11;
        expect_at(6'b000010, 2);
        tick(2);
        chk("prio_hwint", 32'(hwint_out), 32'h02);
        rd(INTC_VECT, 32'h8000_0001, "prio_vect");
        irq_in[2:1] = 2'b00;
        tick(1);
        wr(INTC_VECT, 32'h0);
        tick(4);
        chk("prio_no_src2", 32'(hwint_out), 32'h0);
        chk("prio_idle_busy", 32'(busy), 32'h0);

        // Level source: W1C has no effect while the line is high
        wr(INTC_MASK, 32'h0);
        irq_in[3] = 1'b1;
        tick(1);
        wr(INTC_PEND, 32'h08);
        rd(INTC_PEND, 32'h08, "lvl_w1c_ignored");
        irq_in[3] = 1'b0;
        tick(2);
        rd(INTC_PEND, 32'h0, "lvl_pend_drop");

`ifdef INTC_EDGE_EN
        wr(INTC_MODE, 32'h3F);
        rd(INTC_MODE, 32'h3F, "mode_rw");
        wr(INTC_MODE, 32'h04);
        wr(INTC_MASK, 32'h04);

        // Edge pulse on source 2: pending, delivered, cleared by grant
        irq_in[2] = 1'b1;
        expect_at(6'b000100, 2);
        tick(1);
        irq_in[2] = 1'b0;
        rd(INTC_PEND, 32'h04, "edge_pend_set");
        tick(1);
        rd(INTC_PEND, 32'h0, "edge_pend_granted");
        chk("edge_hwint", 32'(hwint_out), 32'h04);

        // Higher priority source 0 arrives during service: held until EOI
        wr(INTC_MASK, 32'h05);
        irq_in[0] = 1'b1;
        tick(3);
        chk("hold_hwint", 32'(hwint_out), 32'h04);
        rd(INTC_VECT, 32'h8000_0002, "hold_vect");
        expect_at(6'b000001, 2);
        wr(INTC_VECT, 32'h0);
        chk("hold_eoi_gap", 32'(hwint_out), 32'h0);
        tick(1);
        chk("hold_next", 32'(hwint_out), 32'h01);
        irq_in[0] = 1'b0;
        tick(1);
        wr(INTC_VECT, 32'h0);
        tick(3);

        // Edge and W1C in the same cycle: set wins
        wr(INTC_MASK, 32'h0);
        irq_in[2] = 1'b1;
        tick(1);
        irq_in[2] = 1'b0;
        tick(1);
        Addr      = 30'(INTC_PEND);
        Din       = 32'h04;
        WE        = 1'b1;
        irq_in[2] = 1'b1;
        tick(1);
        WE        = 1'b0;
        rd(INTC_PEND, 32'h04, "w1c_vs_edge");
        irq_in[2] = 1'b0;
        wr(INTC_PEND, 32'h04);
        rd(INTC_PEND, 32'h0, "w1c_clear");
`else
        wr(INTC_MODE, 32'h3F);
        rd(INTC_MODE, 32'h0, "mode_absent");
`endif

        // EOI while idle changes nothing; last id stays readable
        wr(INTC_VECT, 32'h0);
        tick(2);
        chk("idle_eoi_busy", 32'(busy), 32'h0);
        chk("idle_eoi_hwint", 32'(hwint_out), 32'h0);
`ifdef INTC_EDGE_EN
        rd(INTC_VECT, 32'h0000_0000, "idle_eoi_vect");
`else
        rd(INTC_VECT, 32'h0000_0001, "idle_eoi_vect");
`endif

        // Reset during service
        wr(INTC_MASK, 32'h01);
        irq_in[0] = 1'b1;
        expect_at(6'b000001, 2);
        tick(2);
        chk("rs_busy_before", 32'(busy), 32'h1);
        reset     = 1'b1;
        irq_in[0] = 1'b0;
        tick(1);
        chk("rs_hwint", 32'(hwint_out), 32'h0);
        chk("rs_busy", 32'(busy), 32'h0);
        rd(INTC_MASK, 32'h0, "rs_mask");
        rd(INTC_VECT, 32'h0, "rs_vect");
        rd(INTC_MODE, 32'h0, "rs_mode");
        reset = 1'b0;
        tick(3);
        chk("rs_quiet", 32'(hwint_out), 32'h0);

        tick(5);
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d outstanding deliveries expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
